// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
// FSM state encoding and default sizing.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // Counter width able to hold WIDTH-1 for a given operand width.
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single 1-bit full adder, reused every cycle
// by the serial add controller.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first,
// WIDTH RUN cycles then a one-cycle DONE pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             fa_s;
  logic             fa_co;
  logic             last;
  logic             accept;

  assign last   = (cnt == LAST);
  assign accept = (state == IDLE) && start;

  full_adder_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: start only matters in IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (last)  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
      res   <= '0;
    end else if (state == RUN) begin
      res   <= {fa_s, res[WIDTH-1:1]};
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= fa_co;
      cnt   <= cnt + 1'b1;
      if (last) cout_q <= fa_co;
    end
  end

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);
  assign sum  = res;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl.
// WIDTH=8; inputs driven and outputs sampled on negedge.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int n_chk;
  int n_fail;

  int         nd;
  int         didx [2];
  logic [7:0] dsum [2];
  logic       dco  [2];

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation; called right after a negedge.
  task automatic run_op(input string tag,
                        input logic [7:0] ia,
                        input logic [7:0] ib,
                        input logic       ic,
                        input logic [7:0] es,
                        input logic       ec);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " run1"}, 32'({busy, done}), 32'h2);
    repeat (7) begin
      @(negedge clk);
      chk({tag, " run"}, 32'({busy, done}), 32'h2);
    end
    @(negedge clk);
    chk({tag, " done"}, 32'({busy, done}), 32'h3);
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    chk({tag, " idle"}, 32'({busy, done}), 32'h0);
    chk({tag, " hold"}, 32'({cout, sum}), 32'({ec, es}));
  endtask

  initial begin
    n_chk = 0; n_fail = 0; nd = 0;
    didx[0] = 0; didx[1] = 0;
    dsum[0] = '0; dsum[1] = '0;
    dco[0] = 1'b0; dco[1] = 1'b0;
    rst_n = 1'b0; start = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("reset", 32'({busy, done, cout, sum}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal add and wrap-around.
    run_op("add5a33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    run_op("ffp01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("ffpffc", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Reset mid-RUN; cout from previous op held until then.
    a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst cout held", 32'(cout), 32'h1);
    repeat (3) @(negedge clk);
    chk("rst pre", 32'({busy, done}), 32'h2);
    #2 rst_n = 1'b0;
    #1 chk("rst async", 32'({busy, done, cout, sum}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst nodone", 32'({busy, done}), 32'h0);
    rst_n = 1'b1;
    run_op("after rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // Start ignored in RUN and DONE; operand changes ignored.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej run", 32'({busy, done}), 32'h2);
    repeat (4) @(negedge clk);
    chk("rej predone", 32'({busy, done}), 32'h2);
    @(negedge clk);
    chk("rej done", 32'({busy, done}), 32'h3);
    chk("rej sum", 32'({cout, sum}), 32'h030);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej idle", 32'({busy, done}), 32'h0);
    chk("rej hold", 32'({cout, sum}), 32'h030);
    @(negedge clk);
    chk("rej stay", 32'({busy, done}), 32'h0);

    // Back-to-back with start held high.
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) begin
        a = 8'h20; b = 8'h05; cin = 1'b1;
      end
      if (done) begin
        if (nd < 2) begin
          didx[nd] = i;
          dsum[nd] = sum;
          dco[nd]  = cout;
        end
        nd++;
        if (nd == 2) start = 1'b0;
      end
    end
    chk("b2b count", 32'(nd), 32'd2);
    chk("b2b first", 32'(didx[0]), 32'd8);
    chk("b2b period", 32'(didx[1] - didx[0]), 32'd10);
    chk("b2b sum0", 32'({dco[0], dsum[0]}), 32'h007);
    chk("b2b sum1", 32'({dco[1], dsum[1]}), 32'h026);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
